// File: rtl/bcd_digit_loader_pkg.sv
// Shared types and constants for the BCD operand loader.
// Holds the entry FSM states plus helpers that map a load state to its operand slot.
package bcd_digit_loader_pkg;

  typedef enum logic [1:0] {
    LOAD1 = 2'd0,
    LOAD2 = 2'd1,
    LOAD3 = 2'd2,
    READY = 2'd3
  } state_t;

  localparam logic [3:0] MAX_BCD_DIGIT = 4'd9;
  localparam int         NUM_OPERANDS  = 3;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= MAX_BCD_DIGIT;
  endfunction

  // LOADk fills operand slot k-1; the enum encoding is chosen so this is a plain cast.
  function automatic logic [1:0] slot_of(input state_t s);
    return 2'(s);
  endfunction

  function automatic state_t advance(input state_t s);
    state_t n;
    case (s)
      LOAD1:   n = LOAD2;
      LOAD2:   n = LOAD3;
      default: n = READY;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_loader_enter_debouncer.sv
// Debounces the raw enter level and emits one press per high period.
// press is combinational so the consumer acts on the same edge the count completes.
module enter_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic press
);

  localparam logic [3:0] TARGET = 4'(DEBOUNCE_CYCLES);

  logic [3:0] count_reg, count_next;
  logic       armed_reg, armed_next;

  assign press = enter && armed_reg && (count_reg == TARGET - 4'd1);

  always_comb begin
    count_next = count_reg;
    armed_next = armed_reg;
    if (!enter) begin
      count_next = 4'd0;
      armed_next = 1'b1;
    end else begin
      if (count_reg != TARGET) begin
        count_next = count_reg + 4'd1;
      end
      if (press) begin
        armed_next = 1'b0;
      end
    end
  end

  // Starting disarmed forces a low sample after reset before the first press.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= 4'd0;
      armed_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      armed_reg <= armed_next;
    end
  end

endmodule

// File: rtl/bcd_digit_loader.sv
// Collects three debounced BCD digits from an operator button and presents them
// as stable operands to a downstream three-digit adder until consumed or cleared.
module bcd_digit_loader
  import bcd_digit_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       enter,
  input  logic       clear,
  input  logic       consume,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic       operands_valid,
  output logic [1:0] digit_count,
  output logic       entry_error
);

  logic press;

  enter_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_debouncer (
    .clock(clock),
    .reset(reset),
    .enter(enter),
    .press(press)
  );

  state_t     state_reg, state_next;
  logic [3:0] num_reg  [NUM_OPERANDS];
  logic [3:0] num_next [NUM_OPERANDS];
  logic [1:0] count_reg, count_next;
  logic       err_reg, err_next;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      num_next[i] = num_reg[i];
    end

    // clear outranks everything; a press seen alongside it is simply dropped.
    if (clear || (state_reg == READY && consume)) begin
      state_next = LOAD1;
      count_next = 2'd0;
      err_next   = 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        num_next[i] = 4'd0;
      end
    end else if (state_reg != READY && press) begin
      if (is_bcd(digit_in)) begin
        num_next[slot_of(state_reg)] = digit_in;
        state_next = advance(state_reg);
        count_next = count_reg + 2'd1;
        err_next   = 1'b0;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LOAD1;
      count_reg <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_operand
      always_ff @(posedge clock) begin
        if (reset) begin
          num_reg[gi] <= 4'd0;
        end else begin
          num_reg[gi] <= num_next[gi];
        end
      end
    end
  endgenerate

  assign num1           = num_reg[0];
  assign num2           = num_reg[1];
  assign num3           = num_reg[2];
  assign digit_count    = count_reg;
  assign entry_error    = err_reg;
  assign operands_valid = (state_reg == READY);

endmodule

// File: tb/tb_bcd_digit_loader.sv
// Directed bench for bcd_digit_loader: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_bcd_digit_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       enter;
  logic       clear;
  logic       consume;
  logic [3:0] num1, num2, num3;
  logic       operands_valid;
  logic [1:0] digit_count;
  logic       entry_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] n1, n2, n3;
    logic [1:0] cnt;
    logic       valid;
    logic       err;
    logic       chk_sum;
    logic [7:0] sum;
  } exp_t;

  exp_t exp_q[$];

  bcd_digit_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .digit_in(digit_in),
    .enter(enter),
    .clear(clear),
    .consume(consume),
    .num1(num1),
    .num2(num2),
    .num3(num3),
    .operands_valid(operands_valid),
    .digit_count(digit_count),
    .entry_error(entry_error)
  );

  always #5 clock = ~clock;

  // Downstream three-digit BCD adder as the operand consumer would compute it.
  function automatic logic [7:0] bcd_sum3(input logic [3:0] a, b, c);
    int bin;
    bin = int'(a) + int'(b) + int'(c);
    return {4'(bin / 10), 4'(bin % 10)};
  endfunction

  task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "num1", 8'(num1), 8'(e.n1));
      chk(e.name, "num2", 8'(num2), 8'(e.n2));
      chk(e.name, "num3", 8'(num3), 8'(e.n3));
      chk(e.name, "digit_count", 8'(digit_count), 8'(e.cnt));
      chk(e.name, "operands_valid", 8'(operands_valid), 8'(e.valid));
      chk(e.name, "entry_error", 8'(entry_error), 8'(e.err));
      if (e.chk_sum) chk(e.name, "adder_sum", bcd_sum3(num1, num2, num3), e.sum);
      $display("checked %s: num=%0h,%0h,%0h count=%0d valid=%0b err=%0b",
               e.name, num1, num2, num3, digit_count, operands_valid, entry_error);
    end
  end

  task automatic step(input logic e, input logic [3:0] d, input logic c, input logic cs, input logic r);
    enter    = e;
    digit_in = d;
    clear    = c;
    consume  = cs;
    reset    = r;
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] n1, n2, n3, input logic [1:0] cnt,
                            input logic valid, err, input logic chk_sum, input logic [7:0] sum);
    exp_t e;
    e.name = nm; e.n1 = n1; e.n2 = n2; e.n3 = n3; e.cnt = cnt;
    e.valid = valid; e.err = err; e.chk_sum = chk_sum; e.sum = sum;
    exp_q.push_back(e);
  endtask

  initial begin
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    low(1);

    // Load 3, 4, 5 and check the adder view.
    hold(4'd3, 4); expect_out("load_d1", 3, 0, 0, 1, 0, 0, 0, 0); low(2);
    hold(4'd4, 4); expect_out("load_d2", 3, 4, 0, 2, 0, 0, 0, 0); low(2);
    hold(4'd5, 4); expect_out("load_d3", 3, 4, 5, 3, 1, 0, 1, 8'h12); low(2);
    expect_out("ready_stable", 3, 4, 5, 3, 1, 0, 1, 8'h12);

    hold(4'd9, 4); low(2);
    expect_out("ready_press_ignored", 3, 4, 5, 3, 1, 0, 0, 0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_out("consume", 0, 0, 0, 0, 0, 0, 0, 0);

    // Non-BCD digit in LOAD2, then a valid retry.
    hold(4'd1, 4); expect_out("load_1", 1, 0, 0, 1, 0, 0, 0, 0); low(2);
    hold(4'hB, 4); expect_out("bad_digit", 1, 0, 0, 1, 0, 1, 0, 0); low(2);
    expect_out("err_persists", 1, 0, 0, 1, 0, 1, 0, 0);
    hold(4'd7, 4); expect_out("retry_7", 1, 7, 0, 2, 0, 0, 0, 0); low(2);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_out("clear", 0, 0, 0, 0, 0, 0, 0, 0);

    // Short pulse and long hold.
    hold(4'd6, 3); low(2);
    expect_out("short_pulse", 0, 0, 0, 0, 0, 0, 0, 0);
    hold(4'd6, 20);
    expect_out("long_hold", 6, 0, 0, 1, 0, 0, 0, 0); low(2);

    // Clear coincident with the qualifying edge in LOAD2.
    hold(4'd5, 3);
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_out("clear_on_press", 0, 0, 0, 0, 0, 0, 0, 0);
    hold(4'd5, 4);
    expect_out("no_rearm_after_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    low(1); hold(4'd8, 4);
    expect_out("rearmed_after_clear", 8, 0, 0, 1, 0, 0, 0, 0); low(2);

    // Reset in LOAD3 with enter held high.
    hold(4'd1, 4); low(2);
    expect_out("to_load3", 8, 1, 0, 2, 0, 0, 0, 0);
    hold(4'd3, 2);
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    expect_out("reset_mid_entry", 0, 0, 0, 0, 0, 0, 0, 0);
    hold(4'd3, 5);
    expect_out("no_press_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    low(1); hold(4'd3, 4);
    expect_out("press_after_rearm", 3, 0, 0, 1, 0, 0, 0, 0); low(2);

    // Error flag cleared by clear; consume outside READY ignored.
    hold(4'hC, 4); low(1);
    expect_out("bad_digit_2", 3, 0, 0, 1, 0, 1, 0, 0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_out("consume_ignored", 3, 0, 0, 1, 0, 1, 0, 0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_out("clear_err", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_digit_loader.md
BCD_DIGIT_LOADER -- requirements
Module: bcd_digit_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive sampled-high edges of enter that form one press, legal range 1..15.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port digit_in  input  4  candidate BCD digit, sampled on the press edge.
REQ-005 SHALL have port enter  input  1  raw level from the operator button.
REQ-006 SHALL have port clear  input  1  abandon the entry and return to empty.
REQ-007 SHALL have port consume  input  1  downstream adder has taken the operands.
REQ-008 SHALL have ports num1, num2, num3  output  4 each  stored BCD operands, wired directly to the three-digit adder.
REQ-009 SHALL have port operands_valid  output  1  high while all three operands are held.
REQ-010 SHALL have port digit_count  output  2  number of digits stored, 0..3.
REQ-011 SHALL have port entry_error  output  1  last press carried a non-BCD digit.

Function
REQ-012 SHALL run a states FSM with states LOAD1, LOAD2, LOAD3 and READY.
REQ-013 SHALL count consecutive edges with enter high, saturating at DEBOUNCE_CYCLES; the count resets to 0 on any edge with enter low.
REQ-014 SHALL recognise a press on the edge where the count reaches DEBOUNCE_CYCLES, only if armed; the press disarms; enter low re-arms.
REQ-015 SHALL produce exactly one press per high period of enter, however long enter is held.
REQ-016 SHALL, on a press in LOADk with digit_in <= 9: store digit_in into numk on that same edge, advance to the next state (LOAD3 -> READY), increment digit_count, and clear entry_error.
REQ-017 SHALL, on a press in LOADk with digit_in >= 10: leave the state and all numk unchanged and set entry_error.
REQ-018 SHALL keep entry_error set until the next valid press, clear or reset.
REQ-019 SHALL drive operands_valid high exactly when the state is READY; num1..num3 SHALL be stable throughout READY.
REQ-020 SHALL ignore presses in READY; they still disarm the press detector.
REQ-021 SHALL, on consume in READY: zero num1..num3, digit_count and entry_error on that edge, and go to LOAD1.
REQ-022 SHALL ignore consume outside READY.
REQ-023 SHALL, on clear in any state: zero num1..num3, digit_count and entry_error, and go to LOAD1.
REQ-024 SHALL give clear priority over a simultaneous press or consume; the press is discarded but still disarms the detector.
REQ-025 SHALL have latency from the qualifying edge to updated outputs of zero additional cycles: all outputs are registered and update on that edge.

Reset
REQ-026 SHALL, on an edge with reset high: set state to LOAD1; drive num1..num3 = 0, digit_count = 0, operands_valid = 0, entry_error = 0; set the debounce count to 0 and the detector to disarmed.
REQ-027 SHALL give reset priority over clear, consume and press.
REQ-028 SHALL, after reset, require enter to be sampled low at least once before any press is recognised; reset mid-entry discards partial digits.

Structure
REQ-029 SHALL declare the following in a shared package: the FSM state enum typedef, constant MAX_BCD_DIGIT = 9, and constant NUM_OPERANDS = 3.
REQ-030 SHALL place debounce, arming and press generation in sub-module enter_debouncer (parameter DEBOUNCE_CYCLES; ports clock, reset, enter, press); press SHALL be combinational from the registered count and armed flag so the store happens on the qualifying edge.

Verification
REQ-031 SHALL cover: DEBOUNCE_CYCLES=4; digits 3, 4, 5 each with enter high 4 edges, then low 2 -> num1=3, num2=4, num3=5, digit_count=3, operands_valid=1; the adder downstream shows sum 8'h12.
REQ-032 SHALL cover: in LOAD2, press with digit_in=4'hB -> entry_error=1, num2=0, digit_count=1; next press with 7 -> num2=7, entry_error=0, digit_count=2.
REQ-033 SHALL cover: enter high 3 edges then low -> no store, digit_count=0; enter held 20 edges with digit_in=6 -> exactly one store, num1=6, digit_count=1.
REQ-034 SHALL cover: in READY, press with 9 -> no change; consume pulse -> the next edge shows operands_valid=0, num1..num3=0, digit_count=0, state LOAD1.
REQ-035 SHALL cover: clear asserted on the 4th enter edge in LOAD2 -> digit not stored, all outputs 0; a further press requires enter low, then 4 high edges.
REQ-036 SHALL cover: reset asserted in LOAD3 with enter held high -> all outputs 0; no press until enter is low for 1 edge, then high for 4 edges.
